// File: rtl/spi_master.sv
// Mode-0 SPI master (CPOL=0, CPHA=0), MSB first.
// Shifts a WIDTH-bit word out on mosi while capturing WIDTH bits from miso
// under a single active-low chip select. Each SCK half-period lasts CLK_DIV
// system clocks. Every output comes straight from a flop.
//
// Handshake: a transfer is accepted on a rising clk edge where start=1 and
// ready=1. tx_data is captured on that same edge. start is ignored while
// ready=0 and is never queued. Completion is signalled by a one-cycle
// rx_valid pulse. rx_data keeps its value until the next completion, or
// until reset clears it.
module spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             sck,
  output logic             cs,
  output logic             mosi,
  input  logic             miso,
  output logic [2:0]       state_dbg
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt, div_next;
  logic [BIT_W-1:0] bit_cnt, bit_next;
  // The MSB goes straight to mosi on accept, so only the remaining bits are kept.
  logic [WIDTH-2:0] tx_shift, tx_shift_next;
  logic [WIDTH-1:0] rx_shift, rx_shift_next;
  logic [WIDTH-1:0] rx_data_next;
  logic             rx_valid_next;
  logic             sck_next;
  logic             cs_next;
  logic             mosi_next;
  logic             ready_next;
  logic             div_done;

  assign div_done  = (div_cnt == DIV_LAST);
  assign state_dbg = state;

  // Next-state and next-output logic. Each state lasts exactly one SCK half-period.
  always_comb begin
    state_next    = state;
    div_next      = div_cnt;
    bit_next      = bit_cnt;
    tx_shift_next = tx_shift;
    rx_shift_next = rx_shift;
    rx_data_next  = rx_data;
    rx_valid_next = 1'b0;
    sck_next      = sck;
    cs_next       = cs;
    mosi_next     = mosi;
    ready_next    = ready;

    if (state != IDLE) begin
      div_next = div_done ? '0 : div_cnt + DIV_W'(1);
    end

    case (state)
      IDLE: begin
        if (start && ready) begin
          tx_shift_next = tx_data[WIDTH-2:0];
          mosi_next     = tx_data[WIDTH-1];
          cs_next       = 1'b0;
          ready_next    = 1'b0;
          div_next      = '0;
          bit_next      = '0;
          state_next    = SETUP;
        end
      end
      SETUP: begin
        if (div_done) begin
          sck_next      = 1'b1;
          rx_shift_next = {rx_shift[WIDTH-2:0], miso};
          state_next    = SCK_HI;
        end
      end
      SCK_HI: begin
        if (div_done) begin
          sck_next = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            // Last falling edge: mosi keeps its value through the hold phase.
            state_next = HOLD;
          end else begin
            bit_next      = bit_cnt + BIT_W'(1);
            mosi_next     = tx_shift[WIDTH-2];
            tx_shift_next = tx_shift << 1;
            state_next    = SCK_LO;
          end
        end
      end
      SCK_LO: begin
        if (div_done) begin
          sck_next      = 1'b1;
          rx_shift_next = {rx_shift[WIDTH-2:0], miso};
          state_next    = SCK_HI;
        end
      end
      HOLD: begin
        if (div_done) begin
          cs_next       = 1'b1;
          mosi_next     = 1'b0;
          rx_data_next  = rx_shift;
          rx_valid_next = 1'b1;
          state_next    = GAP;
        end
      end
      GAP: begin
        // Keeps cs high for at least one half-period between transfers.
        if (div_done) begin
          ready_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. Reset aborts any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      sck      <= 1'b0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      state    <= state_next;
      div_cnt  <= div_next;
      bit_cnt  <= bit_next;
      tx_shift <= tx_shift_next;
      rx_shift <= rx_shift_next;
      rx_data  <= rx_data_next;
      rx_valid <= rx_valid_next;
      sck      <= sck_next;
      cs       <= cs_next;
      mosi     <= mosi_next;
      ready    <= ready_next;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master.
// Instance dut: WIDTH=8, CLK_DIV=2, attached to a mode-0 slave model.
// Instance dut_lb: WIDTH=8, CLK_DIV=1, with mosi looped back to miso.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ready, rx_valid, sck, cs, mosi, miso;
  logic [7:0] rx_data;
  logic [2:0] state_dbg;

  logic       start_lb = 1'b0;
  logic [7:0] tx_lb = 8'h00;
  logic       ready_lb, rx_valid_lb, sck_lb, cs_lb, mosi_lb;
  logic [7:0] rx_data_lb;
  logic [2:0] state_dbg_lb;

  int tests = 0;
  int fails = 0;

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  spi_master #(.WIDTH(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .ready(ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .sck(sck), .cs(cs), .mosi(mosi), .miso(miso), .state_dbg(state_dbg)
  );

  spi_master #(.WIDTH(8), .CLK_DIV(1)) dut_lb (
    .clk(clk), .rst(rst), .start(start_lb), .tx_data(tx_lb),
    .ready(ready_lb), .rx_data(rx_data_lb), .rx_valid(rx_valid_lb),
    .sck(sck_lb), .cs(cs_lb), .mosi(mosi_lb), .miso(mosi_lb), .state_dbg(state_dbg_lb)
  );

  // Mode-0 slave model: loads slave_word when cs falls, shifts out on sck falling
  // edges and captures mosi on sck rising edges.
  logic [7:0] slave_word = 8'h00;
  logic [7:0] slave_tx = 8'h00;
  logic [7:0] slave_rx = 8'h00;
  int sck_rises = 0;
  int cs_falls = 0;
  int valid_cnt = 0;

  assign miso = slave_tx[7];

  always @(negedge cs) begin
    slave_tx = slave_word;
    slave_rx = 8'h00;
    cs_falls = cs_falls + 1;
  end

  always @(negedge sck) begin
    if (cs === 1'b0) slave_tx = {slave_tx[6:0], 1'b0};
  end

  always @(posedge sck) begin
    if (cs === 1'b0) begin
      slave_rx  = {slave_rx[6:0], mosi};
      sck_rises = sck_rises + 1;
    end
  end

  always @(posedge clk) begin
    if (rx_valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int base_f;
    base_f = cs_falls;
    rst = 1'b1; start = 1'b1; tx_data = 8'hAA;
    repeat (3) begin
      tick;
      tests++; if (cs !== 1'b1) begin fails++; $display("FAIL reset_cs got %b exp 1", cs); end
      tests++; if (sck !== 1'b0) begin fails++; $display("FAIL reset_sck got %b exp 0", sck); end
      tests++; if (mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi got %b exp 0", mosi); end
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ready); end
      tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
      tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
      tests++; if (cs_lb !== 1'b1 || sck_lb !== 1'b0 || ready_lb !== 1'b1) begin
        fails++; $display("FAIL reset_lb got cs=%b sck=%b ready=%b exp 1 0 1", cs_lb, sck_lb, ready_lb);
      end
    end
    rst = 1'b0; start = 1'b0;
    tick;
    tests++; if (cs_falls - base_f != 0) begin fails++; $display("FAIL reset_start_cs_fall got %0d exp 0", cs_falls - base_f); end
  endtask

  task automatic test_basic;
    int base_r, base_v, bi;
    logic [7:0] w;
    logic exp_sck, exp_cs, exp_rv, exp_rdy, exp_mosi;
    w = 8'hA5;
    slave_word = 8'h3C;
    base_r = sck_rises; base_v = valid_cnt;
    tx_data = w; start = 1'b1;
    tick;  // edge 0
    start = 1'b0;
    tests++; if (cs !== 1'b0) begin fails++; $display("FAIL basic_accept_cs got %b exp 0", cs); end
    tests++; if (mosi !== 1'b1) begin fails++; $display("FAIL basic_accept_mosi got %b exp 1", mosi); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL basic_accept_ready got %b exp 0", ready); end
    for (int n = 1; n <= 36; n++) begin
      tick;
      exp_sck = (n >= 2) && (n <= 33) && (((n - 2) % 4) < 2);
      exp_cs  = (n >= 34);
      exp_rv  = (n == 34);
      exp_rdy = (n >= 36);
      bi = n / 4;
      if (bi > 7) bi = 7;
      exp_mosi = (n >= 34) ? 1'b0 : w[7 - bi];
      tests++; if (sck !== exp_sck) begin fails++; $display("FAIL basic_sck edge %0d got %b exp %b", n, sck, exp_sck); end
      tests++; if (cs !== exp_cs) begin fails++; $display("FAIL basic_cs edge %0d got %b exp %b", n, cs, exp_cs); end
      tests++; if (rx_valid !== exp_rv) begin fails++; $display("FAIL basic_rx_valid edge %0d got %b exp %b", n, rx_valid, exp_rv); end
      tests++; if (ready !== exp_rdy) begin fails++; $display("FAIL basic_ready edge %0d got %b exp %b", n, ready, exp_rdy); end
      tests++; if (mosi !== exp_mosi) begin fails++; $display("FAIL basic_mosi edge %0d got %b exp %b", n, mosi, exp_mosi); end
    end
    tests++; if (slave_rx !== 8'hA5) begin fails++; $display("FAIL basic_slave_rx got %h exp a5", slave_rx); end
    tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL basic_rx_data got %h exp 3c", rx_data); end
    tests++; if (sck_rises - base_r != 8) begin fails++; $display("FAIL basic_sck_rises got %0d exp 8", sck_rises - base_r); end
    tests++; if (valid_cnt - base_v != 1) begin fails++; $display("FAIL basic_valid_count got %0d exp 1", valid_cnt - base_v); end
  endtask

  task automatic test_loopback;
    logic [7:0] words [3];
    logic got;
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h81;
    for (int i = 0; i < 3; i++) begin
      tx_lb = words[i]; start_lb = 1'b1;
      tick;
      start_lb = 1'b0;
      got = 1'b0;
      for (int n = 1; n <= 40; n++) begin
        tick;
        if (i == 0 && n <= 16) begin
          tests++; if (sck_lb !== n[0]) begin fails++; $display("FAIL loop_sck edge %0d got %b exp %b", n, sck_lb, n[0]); end
        end
        if (rx_valid_lb === 1'b1) begin
          got = 1'b1;
          tests++; if (rx_data_lb !== words[i]) begin fails++; $display("FAIL loop_rx_data got %h exp %h", rx_data_lb, words[i]); end
        end
      end
      tests++; if (got !== 1'b1) begin fails++; $display("FAIL loop_timeout word %h got no rx_valid exp 1", words[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int base_v, base_f, first_v, second_v;
    slave_word = 8'h3C;
    base_v = valid_cnt; base_f = cs_falls;
    first_v = -1; second_v = -1;
    tx_data = 8'h12; start = 1'b1;
    tick;  // edge 0
    tx_data = 8'h34;
    for (int n = 1; n <= 75; n++) begin
      tick;
      if (rx_valid === 1'b1) begin
        if (first_v < 0) first_v = n; else second_v = n;
      end
      if (n == 35) begin
        tests++; if (slave_rx !== 8'h12) begin fails++; $display("FAIL b2b_first_slave_rx got %h exp 12", slave_rx); end
      end
      if (n >= 34 && n <= 36) begin
        tests++; if (cs !== 1'b1) begin fails++; $display("FAIL b2b_cs_gap edge %0d got %b exp 1", n, cs); end
      end
      if (n == 37) begin
        tests++; if (cs !== 1'b0) begin fails++; $display("FAIL b2b_cs_fall edge 37 got %b exp 0", cs); end
        start = 1'b0;
      end
    end
    tests++; if (first_v != 34) begin fails++; $display("FAIL b2b_first_valid got %0d exp 34", first_v); end
    tests++; if (second_v != 71) begin fails++; $display("FAIL b2b_second_valid got %0d exp 71", second_v); end
    tests++; if (valid_cnt - base_v != 2) begin fails++; $display("FAIL b2b_valid_count got %0d exp 2", valid_cnt - base_v); end
    tests++; if (cs_falls - base_f != 2) begin fails++; $display("FAIL b2b_cs_falls got %0d exp 2", cs_falls - base_f); end
    tests++; if (slave_rx !== 8'h34) begin fails++; $display("FAIL b2b_second_slave_rx got %h exp 34", slave_rx); end
  endtask

  task automatic test_busy;
    int base_v, base_f;
    slave_word = 8'h96;
    base_v = valid_cnt; base_f = cs_falls;
    tx_data = 8'h55; start = 1'b1;
    tick;  // edge 0
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 10) begin start = 1'b1; tx_data = 8'hFF; end
      tick;
      if (n == 10) start = 1'b0;
    end
    tests++; if (slave_rx !== 8'h55) begin fails++; $display("FAIL busy_slave_rx got %h exp 55", slave_rx); end
    tests++; if (cs_falls - base_f != 1) begin fails++; $display("FAIL busy_cs_falls got %0d exp 1", cs_falls - base_f); end
    tests++; if (valid_cnt - base_v != 1) begin fails++; $display("FAIL busy_valid_count got %0d exp 1", valid_cnt - base_v); end
    tests++; if (rx_data !== 8'h96) begin fails++; $display("FAIL busy_rx_data got %h exp 96", rx_data); end
    tests++; if (ready !== 1'b1 || cs !== 1'b1) begin fails++; $display("FAIL busy_idle got ready=%b cs=%b exp 1 1", ready, cs); end
  endtask

  task automatic test_reset_mid;
    int base_v;
    slave_word = 8'hE7;
    base_v = valid_cnt;
    tx_data = 8'hF0; start = 1'b1;
    tick;  // edge 0
    start = 1'b0;
    for (int n = 1; n <= 14; n++) tick;
    rst = 1'b1;
    tick;  // edge 15
    rst = 1'b0;
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL midrst_cs got %b exp 1", cs); end
    tests++; if (sck !== 1'b0) begin fails++; $display("FAIL midrst_sck got %b exp 0", sck); end
    tests++; if (mosi !== 1'b0) begin fails++; $display("FAIL midrst_mosi got %b exp 0", mosi); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %b exp 1", ready); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL midrst_rx_data got %h exp 00", rx_data); end
    repeat (40) tick;
    tests++; if (valid_cnt - base_v != 0) begin fails++; $display("FAIL midrst_no_valid got %0d exp 0", valid_cnt - base_v); end
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL midrst_cs_idle got %b exp 1", cs); end
    slave_word = 8'h5A;
    tx_data = 8'hC3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (40) tick;
    tests++; if (slave_rx !== 8'hC3) begin fails++; $display("FAIL midrst_after_slave_rx got %h exp c3", slave_rx); end
    tests++; if (rx_data !== 8'h5A) begin fails++; $display("FAIL midrst_after_rx_data got %h exp 5a", rx_data); end
    tests++; if (valid_cnt - base_v != 1) begin fails++; $display("FAIL midrst_after_valid got %0d exp 1", valid_cnt - base_v); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset;
    test_basic;
    test_loopback;
    test_back_to_back;
    test_busy;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Mode-0 SPI master. It serialises a WIDTH-bit parallel word onto MOSI and simultaneously captures WIDTH bits from MISO, MSB first, under one active-low chip select per transfer. It drives the SPI slave shift-register blocks in this design, and the bench uses it to exercise them. The SPI clock is derived from the system clock by a programmable half-period divider.

## Interface
- `WIDTH`, 8: bits per transfer; must be at least 2.
- `CLK_DIV`, 2: system clocks per SCK half-period (H); must be at least 1.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  transfer request; sampled only when `ready`=1.
- `tx_data`  in  WIDTH  word to send; captured on the accepting edge.
- `ready`  out  1  block idle, able to accept `start`.
- `rx_data`  out  WIDTH  last received word; valid while `rx_valid`=1 and held until the next completion.
- `rx_valid`  out  1  one-cycle completion pulse.
- `sck`  out  1  SPI clock; idles low (CPOL=0).
- `cs`  out  1  chip select, active low.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in; no synchroniser is required because it is sampled at least H clocks after the slave updates it.

## Operation
- States: IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP. One divider counter (0..H-1) and one bit counter (0..WIDTH-1).
- Accept: `start` && `ready` at edge 0. On that edge:
  - `tx_data` is loaded into the shift register.
  - `cs` goes to 0, `mosi` goes to `tx_data[WIDTH-1]`, `ready` goes to 0.
  - State enters SETUP.
- SETUP → SCK_HI after H clocks. `sck` rises and `miso` is shifted into the LSB of the receive register on the same edge.
- SCK_HI → SCK_LO after H clocks. `sck` falls. If bits remain, `mosi` advances to the next bit (MSB first). After the WIDTH-th fall, `mosi` holds its value and the state goes to HOLD.
- SCK_LO → SCK_HI after H clocks while the bit counter is below WIDTH.
- HOLD → GAP after H clocks. On that edge `cs` goes to 1, `mosi` goes to 0, `rx_data` is loaded and `rx_valid` pulses.
- GAP → IDLE after H clocks, and `ready` goes to 1. This guarantees a minimum `cs`-high time of H clocks.
- `start` while `ready`=0 is ignored and not queued.
- `start` held high continuously gives back-to-back transfers. Each one is accepted on the first edge where `ready`=1.
- `rx_data` shift is MSB-first: the first sampled bit lands in `rx_data[WIDTH-1]`.
- Reset values: `cs`=1, `sck`=0, `mosi`=0, `ready`=1, `rx_valid`=0, `rx_data`=0, state IDLE, counters 0.
- Reset mid-transfer aborts it: on the next edge `cs`=1 and `sck`=0, there is no `rx_valid`, and `rx_data` is cleared.
- Simultaneous `rst` and `start`: reset wins and the transfer is not accepted.

## Timing
- Edge numbering is relative to the accepting edge 0. All outputs are registered.
- `sck` rising edges occur at edges (2k+1)·H, k=0..WIDTH-1. Falling edges occur at 2k·H, k=1..WIDTH.
- Bit k is sampled from `miso` at edge (2k+1)·H.
- `mosi` for bit k is valid from edge 2k·H. It is stable H clocks before and after each `sck` rise.
- `cs` low spans edges 0 through (2·WIDTH+1)·H.
- `rx_valid` is high for the single cycle following edge (2·WIDTH+1)·H.
- `ready` is 1 from edge (2·WIDTH+2)·H. The earliest next accept is edge (2·WIDTH+2)·H+1.
- With WIDTH=8 and CLK_DIV=2:
  - `sck` rises at 2,6,…,30 and falls at 4,…,32.
  - `cs` rises at 34, which is also where `rx_valid` occurs.
  - `ready` is 1 at 36.

## Test plan
- Basic transfer (WIDTH=8, CLK_DIV=2): a slave model returns 0x3C and `tx_data`=0xA5.
  - Slave receives 0xA5 and `rx_data`=0x3C.
  - `rx_valid` pulses once, in the cycle after edge 34.
  - Exactly 8 `sck` rising edges occur while `cs`=0.
- Loopback with `mosi` tied to `miso`, CLK_DIV=1: send 0x00, 0xFF and 0x81 → `rx_data` equals `tx_data` each time, and `sck` period is 2 clocks.
- Back-to-back: `start` held high, `tx_data` 0x12 then 0x34.
  - Second `cs` fall occurs exactly at edge 37, giving `cs` high for 3 clocks including the GAP.
  - Two `rx_valid` pulses occur.
- Busy request: pulse `start` with 0xFF at edge 10 of a 0x55 transfer → wire carries only 0x55, with no extra transfer afterwards.
- Reset mid-transfer: assert `rst` at edge 15.
  - Next cycle shows `cs`=1, `sck`=0, `mosi`=0, `ready`=1.
  - No `rx_valid` pulse.
  - `rx_data`=0.
  - A following 0xC3 transfer completes correctly.
- Reset behaviour: `rst` with `start`=1 gives no `cs` fall. All outputs equal their reset values while `rst` is held.
